// File: rtl/alu_disp_pkg.sv
// Shared types, segment constants and the 7-segment digit table for alu_result_display.
package alu_disp_pkg;

  typedef enum logic [1:0] {IDLE, CONVERT, SHOW} state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;

  // Active-low segments, bit0=a .. bit6=g, bit7=dp.
  function automatic logic [7:0] seg7_digit(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_result_display_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, one-cycle pulse on accepted press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          meta_q, sync_q, level_q;
  logic [CW-1:0] cnt_q;
  logic          done;

  // Counter only runs while the synced level disagrees with the accepted level,
  // so any bounce back to the accepted level restarts it.
  assign done   = (sync_q != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
  assign rise_o = done && sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      if (sync_q == level_q) begin
        cnt_q <= '0;
      end else if (done) begin
        level_q <= sync_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_result_display.sv
// Captures ALU result/flags on a debounced press, converts magnitude to BCD and drives 3 digits.
// Optional blinking on overflow when ALU_DISP_BLINK_EN is defined.
module alu_result_display
  import alu_disp_pkg::*;
#(
  parameter int W               = 5,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLINK_DIV       = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_capture,
  input  logic         signed_mode,
  input  logic [W-1:0] alu_out,
  input  logic         alu_zero,
  input  logic         alu_overflow,
  input  logic         alu_carry,
  output logic [7:0]   seg_sign,
  output logic [7:0]   seg_tens,
  output logic [7:0]   seg_ones,
  output logic [2:0]   flag_led,
  output logic         busy,
  output logic         valid
);

  localparam int CW = $clog2(W + 1);

  state_e        state_q, state_d;
  logic          cap;
  logic [W-1:0]  sh_q, mag_in;
  logic [7:0]    bcd_q, bcd_d;
  logic [3:0]    tens_adj, ones_adj;
  logic [CW-1:0] bit_q;
  logic          neg_q, neg_in, last;
  logic [2:0]    flag_q, flag_led_q;
  logic [7:0]    sign_q, tens_q, ones_q;
  logic          valid_q, blank;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_capture),
    .rise_o (cap)
  );

  assign neg_in = signed_mode && alu_out[W-1];
  assign mag_in = neg_in ? (~alu_out + W'(1)) : alu_out;

  // One double-dabble step: add-3 on nibbles >=5, then shift in next magnitude bit.
  assign tens_adj = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
  assign ones_adj = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
  assign bcd_d    = {tens_adj[2:0], ones_adj, sh_q[W-1]};
  assign last     = (bit_q == CW'(W - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, SHOW: if (cap)  state_d = CONVERT;
      CONVERT:    if (last) state_d = SHOW;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      bcd_q      <= '0;
      bit_q      <= '0;
      neg_q      <= 1'b0;
      flag_q     <= '0;
      flag_led_q <= '0;
      sign_q     <= SEG_BLANK;
      tens_q     <= SEG_BLANK;
      ones_q     <= SEG_BLANK;
      valid_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q != CONVERT && cap) begin
        sh_q   <= mag_in;
        neg_q  <= neg_in;
        flag_q <= {alu_carry, alu_overflow, alu_zero};
        bcd_q  <= '0;
        bit_q  <= '0;
      end else if (state_q == CONVERT) begin
        sh_q  <= sh_q << 1;
        bcd_q <= bcd_d;
        bit_q <= bit_q + CW'(1);
        if (last) begin
          sign_q     <= neg_q ? SEG_MINUS : SEG_BLANK;
          tens_q     <= (bcd_d[7:4] == 4'd0) ? SEG_BLANK : seg7_digit(bcd_d[7:4]);
          ones_q     <= seg7_digit(bcd_d[3:0]);
          flag_led_q <= flag_q;
          valid_q    <= 1'b1;
        end
      end
    end
  end

`ifdef ALU_DISP_BLINK_EN
  logic [BLINK_DIV-1:0] blink_q;

  always_ff @(posedge clk) begin
    if (rst) blink_q <= '0;
    else     blink_q <= blink_q + BLINK_DIV'(1);
  end

  assign blank = (state_q == SHOW) && flag_led_q[1] && blink_q[BLINK_DIV-1];
`else
  // Steady display; the divider width has no effect in this build.
  assign blank = (BLINK_DIV < 0);
`endif

  assign seg_sign = blank ? SEG_BLANK : sign_q;
  assign seg_tens = blank ? SEG_BLANK : tens_q;
  assign seg_ones = blank ? SEG_BLANK : ones_q;
  assign flag_led = flag_led_q;
  assign busy     = (state_q == CONVERT);
  assign valid    = valid_q;

endmodule

// File: tb/tb_alu_result_display.sv
// Scoreboard bench for alu_result_display (DEBOUNCE_CYCLES=4, BLINK_DIV=4).
module tb_alu_result_display;

  logic       clk = 1'b0, rst = 1'b1, btn = 1'b0, sm = 1'b0;
  logic [4:0] aluv = '0;
  logic       az = 1'b0, ao = 1'b0, ac = 1'b0;
  logic [7:0] ss, st, so;
  logic [2:0] fl;
  logic       busy, valid;

  always #5 clk = ~clk;

  alu_result_display #(.W(5), .DEBOUNCE_CYCLES(4), .BLINK_DIV(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_capture  (btn),
    .signed_mode  (sm),
    .alu_out      (aluv),
    .alu_zero     (az),
    .alu_overflow (ao),
    .alu_carry    (ac),
    .seg_sign     (ss),
    .seg_tens     (st),
    .seg_ones     (so),
    .flag_led     (fl),
    .busy         (busy),
    .valid        (valid)
  );

  typedef struct packed {
    logic [7:0] s, t, o;
    logic [2:0] f;
  } exp_t;

  exp_t q[$];
  exp_t cur = '{s: 8'hFF, t: 8'hFF, o: 8'hFF, f: 3'b000};
  logic valid_exp = 1'b0;
  logic busy_prev = 1'b0;
  int   n_chk = 0, n_fail = 0, n_conv = 0, busy_len = 0;

  localparam logic [7:0] DIG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

`ifdef ALU_DISP_BLINK_EN
  logic [3:0] bm = '0;
  always @(posedge clk) bm <= rst ? 4'd0 : bm + 4'd1;
`endif

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] v, input logic s, input logic [2:0] f);
    exp_t       e;
    logic       neg;
    logic [5:0] mag;
    int         tens, ones;
    neg  = s && v[4];
    mag  = neg ? 6'd32 - {1'b0, v} : {1'b0, v};
    tens = int'(mag) / 10;
    ones = int'(mag) % 10;
    e.s  = neg ? 8'hBF : 8'hFF;
    e.t  = (tens == 0) ? 8'hFF : DIG[tens];
    e.o  = DIG[ones];
    e.f  = f;
    return e;
  endfunction

  function automatic logic [7:0] eseg(input logic [7:0] v, input logic show);
    logic blank;
`ifdef ALU_DISP_BLINK_EN
    blank = show && cur.f[1] && bm[3];
`else
    blank = show && 1'b0;
`endif
    return blank ? 8'hFF : v;
  endfunction

  // Result monitor: pops the scoreboard whenever a conversion completes.
  always @(negedge clk) begin
    exp_t e;
    if (busy && !busy_prev) begin
      busy_len = 1;
      chk("valid_at_convert", valid, valid_exp);
      if (valid_exp) begin
        chk("hold_tens", st, cur.t);
        chk("hold_ones", so, cur.o);
      end
    end else if (busy) begin
      busy_len++;
    end
    if (!busy && busy_prev && !rst) begin
      n_conv++;
      chk("busy_len", busy_len, 5);
      if (q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = q.pop_front();
        cur = e;
        valid_exp = 1'b1;
        chk("sign", ss, eseg(e.s, 1'b1));
        chk("tens", st, eseg(e.t, 1'b1));
        chk("ones", so, eseg(e.o, 1'b1));
        chk("flags", fl, e.f);
        chk("valid", valid, 1);
      end
    end
    busy_prev = busy;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() > 0; i++) tick(1);
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic wait_busy(input string tag);
    for (int i = 0; i < 50 && !busy; i++) tick(1);
    chk(tag, busy, 1);
  endtask

  task automatic press(input logic [4:0] v, input logic s, input logic [2:0] f);
    aluv = v; sm = s; {ac, ao, az} = f;
    q.push_back(mk(v, s, f));
    btn = 1'b1;
    tick(10);
    btn = 1'b0;
    tick(10);
    drain();
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "_sign"}, ss, 8'hFF);
    chk({tag, "_tens"}, st, 8'hFF);
    chk({tag, "_ones"}, so, 8'hFF);
    chk({tag, "_flags"}, fl, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int saved;
    // Reset with the button held down.
    rst = 1'b1; btn = 1'b1;
    tick(3);
    chk_blank("reset");
    btn = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);

    press(5'd27, 1'b0, 3'b000);
    press(5'b10000, 1'b1, 3'b000);

    // Bouncing button: never stable for 4 cycles.
    saved = n_conv;
    for (int i = 0; i < 20; i++) begin
      btn = ~btn;
      tick(2);
    end
    btn = 1'b0;
    tick(10);
    chk("bounce_no_capture", n_conv, saved);
    chk("bounce_valid", valid, 1);
    chk("bounce_sign", ss, cur.s);
    chk("bounce_ones", so, cur.o);

    // Zero result; button activity and new operand during conversion.
    saved = n_conv;
    aluv = 5'd0; sm = 1'b0; {ac, ao, az} = 3'b001;
    q.push_back(mk(5'd0, 1'b0, 3'b001));
    btn = 1'b1;
    wait_busy("busy_seen_zero");
    aluv = 5'd9; az = 1'b0;
    tick(1);
    btn = 1'b0; tick(2);
    btn = 1'b1; tick(2);
    btn = 1'b0;
    tick(20);
    drain();
    chk("zero_single_conv", n_conv, saved + 1);
    chk("zero_tens", st, 8'hFF);
    chk("zero_ones", so, 8'hC0);

    // Overflow result: blinking with the macro, steady without.
    press(5'd13, 1'b0, 3'b110);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("blink_tens", st, eseg(cur.t, 1'b1));
      chk("blink_ones", so, eseg(cur.o, 1'b1));
    end
    tick(1);

    // Reset in the middle of a conversion.
    saved = n_conv;
    aluv = 5'd7; {ac, ao, az} = 3'b000;
    btn = 1'b1;
    wait_busy("busy_seen_rst");
    tick(2);
    rst = 1'b1;
    tick(1);
    chk_blank("midrst");
    valid_exp = 1'b0;
    btn = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(10);
    chk("midrst_no_result", n_conv, saved);
    chk("midrst_valid", valid, 0);

    press(5'd20, 1'b1, 3'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
